float_to_fixed: RTL

//   Pipelined IEEE-style float -> signed fixed-point converter; inverse of fixed_to_float.

---
 rtl/f2f_fmt_pkg.sv | 26 ++
 rtl/f2x_shift_round.sv | 55 +++++
 rtl/float_to_fixed.sv | 136 +++++++++++++
 3 files changed

// File: rtl/f2f_fmt_pkg.sv
// Float format descriptors and value classes shared by float_to_fixed and fixed_to_float.
package f2f_fmt_pkg;

  typedef enum logic [1:0] {CLS_ZERO, CLS_NORM, CLS_INF, CLS_NAN} f2f_cls_e;

  function automatic int fmt_exp_wid(string fmt);
    if (fmt == "double")  return 11;
    if (fmt == "byte_10") return 15;
    return 8;
  endfunction

  function automatic int fmt_mant_wid(string fmt);
    if (fmt == "double")  return 52;
    if (fmt == "byte_10") return 64;
    return 23;
  endfunction

  function automatic int fmt_exp_bias(string fmt);
    return (1 << (fmt_exp_wid(fmt) - 1)) - 1;
  endfunction

  function automatic int fmt_float_wid(string fmt);
    return 1 + fmt_exp_wid(fmt) + fmt_mant_wid(fmt);
  endfunction

endpackage

// File: rtl/f2x_shift_round.sv
// Two-level barrel shifter: coarse (multiple of 8) then fine shift, yielding magnitude,
// round bit and a flag for set bits above the output width.
module f2x_shift_round #(
  parameter int MW = 24,
  parameter int W  = 32,
  parameter int AW = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clk_en,
  input  logic [MW-1:0] m,
  input  logic [AW-1:0] amt,
  input  logic          zero,
  input  logic          big,
  output logic [W-1:0]  mag,
  output logic          rnd,
  output logic          hi
);
  localparam int TW = 2*MW + W;
  localparam int TU = MW + W;
  localparam int FB = 3;

  logic [TW-1:0] t2;
  logic [FB-1:0] fa2;
  logic          big2;
  logic [TU-1:0] tu;

  // {m,0} << amt puts the integer LSB at bit MW+1 and the round bit at bit MW.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      t2   <= '0;
      fa2  <= '0;
      big2 <= 1'b0;
    end else if (clk_en) begin
      t2   <= (zero | big) ? '0 : (TW'({m, 1'b0}) << {amt[AW-1:FB], {FB{1'b0}}});
      fa2  <= amt[FB-1:0];
      big2 <= big;
    end
  end

  assign tu = TU'((t2 << fa2) >> MW);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mag <= '0;
      rnd <= 1'b0;
      hi  <= 1'b0;
    end else if (clk_en) begin
      mag <= tu[W:1];
      rnd <= tu[0];
      hi  <= big2 | (|tu[TU-1:W+1]);
    end
  end

endmodule

// File: rtl/float_to_fixed.sv
// Pipelined float -> signed fixed-point converter, 4 enabled cycles of latency.
// Define F2X_SATURATE_EN to clamp out-of-range/Inf results instead of wrapping.
module float_to_fixed
  import f2f_fmt_pkg::*;
#(
  parameter string FLOAT_FMT = "float",
  parameter int    INT_WID   = 16,
  parameter int    FRA_WID   = 16,
  localparam int   FLOAT_WID = fmt_float_wid(FLOAT_FMT)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clk_en,
  input  logic                 in_valid,
  input  logic [FLOAT_WID-1:0] float_val,
  output logic                 out_valid,
  output logic [INT_WID-1:0]   fixed_integer,
  output logic [FRA_WID-1:0]   fixed_fraction,
  output logic                 overflow
);
  localparam int EW     = fmt_exp_wid(FLOAT_FMT);
  localparam int MANT   = fmt_mant_wid(FLOAT_FMT);
  localparam int BIAS   = fmt_exp_bias(FLOAT_FMT);
  localparam int MW     = MANT + 1;
  localparam int W      = INT_WID + FRA_WID;
  localparam int KW     = EW + 2;
  localparam int AW     = $clog2(MW + W);
  localparam int STAGES = 3;
  localparam logic signed [KW-1:0] K_OFF = KW'(BIAS + MANT - FRA_WID);
  localparam logic signed [KW-1:0] K_HI  = KW'(W - 1);
  localparam logic signed [KW-1:0] K_LO  = KW'(-MW);

  typedef struct packed {
    logic          sign;
    f2f_cls_e      cls;
    logic [MW-1:0] m;
    logic [AW-1:0] amt;
    logic          zero;
    logic          big;
  } s1_t;

  logic [STAGES:0]     vld_pipe;
  s1_t                 s1_d, s1;
  logic [EW-1:0]       f_exp;
  logic [MANT-1:0]     f_mant;
  logic signed [KW-1:0] k;
  f2f_cls_e            cls;
  logic                sign2, sign3;
  f2f_cls_e            cls2, cls3;
  logic [W-1:0]        mag3, res;
  logic                rnd3, hi3, ovf_mag, ovf_n;
  logic [W:0]          sum;

  // S1 decode: shift amount is biased by MW so both shift directions become one left shift.
  always_comb begin
    f_exp  = float_val[FLOAT_WID-2 -: EW];
    f_mant = float_val[MANT-1:0];
    k      = $signed({2'b00, f_exp}) - K_OFF;
    cls    = CLS_NORM;
    if (f_exp == '0)  cls = CLS_ZERO;
    else if (&f_exp)  cls = (f_mant == '0) ? CLS_INF : CLS_NAN;
    s1_d.sign = float_val[FLOAT_WID-1];
    s1_d.cls  = cls;
    s1_d.m    = {1'b1, f_mant};
    s1_d.zero = (cls == CLS_ZERO) | (cls == CLS_NAN) | ((cls == CLS_NORM) && (k < K_LO));
    s1_d.big  = (cls == CLS_INF) | ((cls == CLS_NORM) && (k > K_HI));
    s1_d.amt  = AW'(k - K_LO);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
      s1       <= '0;
      sign2    <= 1'b0;
      sign3    <= 1'b0;
      cls2     <= CLS_ZERO;
      cls3     <= CLS_ZERO;
    end else if (clk_en) begin
      vld_pipe <= {vld_pipe[STAGES-1:0], in_valid};
      s1       <= s1_d;
      sign2    <= s1.sign;
      cls2     <= s1.cls;
      sign3    <= sign2;
      cls3     <= cls2;
    end
  end

  f2x_shift_round #(.MW(MW), .W(W), .AW(AW)) u_shift (
    .clk    (clk),
    .rst    (rst),
    .clk_en (clk_en),
    .m      (s1.m),
    .amt    (s1.amt),
    .zero   (s1.zero),
    .big    (s1.big),
    .mag    (mag3),
    .rnd    (rnd3),
    .hi     (hi3)
  );

  // S4: round half away on magnitude; the exact minimum negative value is in range.
  always_comb begin
    sum     = {1'b0, mag3} + {{W{1'b0}}, rnd3};
    ovf_mag = hi3 | sum[W] | (sum[W-1] & ~(sign3 & ~|sum[W-2:0]));
    res     = sign3 ? W'(-sum[W-1:0]) : sum[W-1:0];
    ovf_n   = 1'b0;
    if (cls3 == CLS_NAN) begin
      res   = '0;
      ovf_n = 1'b1;
    end else if (ovf_mag) begin
      ovf_n = 1'b1;
`ifdef F2X_SATURATE_EN
      res   = sign3 ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
`endif
    end
    if (!vld_pipe[STAGES-1]) begin
      res   = '0;
      ovf_n = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fixed_integer  <= '0;
      fixed_fraction <= '0;
      overflow       <= 1'b0;
    end else if (clk_en) begin
      fixed_integer  <= res[W-1:FRA_WID];
      fixed_fraction <= res[FRA_WID-1:0];
      overflow       <= ovf_n;
    end
  end

  assign out_valid = vld_pipe[STAGES];

endmodule
